// File: rtl/reg_bank_writer.sv
// Write side of a DEPTH x WIDTH register bank: byte-enabled writes plus a bulk-clear sweep; every entry is exposed on q_flat.
// Latency: a write is visible on q_flat 1 clock after acceptance, with wr_ack pulsing in that cycle. Backpressure: wr_ready is low for the DEPTH cycles of a clear.
// Option: REG_BANK_ZERO_REG_EN makes entry 0 read as constant zero and discards writes to it.
module reg_bank_writer #(
  parameter int DEPTH  = 128,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH/8-1:0]       wr_be,
  output logic                     wr_ack,
  input  logic                     clear_req,
  output logic                     busy,
  output logic [DEPTH*WIDTH-1:0]   q_flat
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_fire;
  logic              wr_store;

  assign wr_fire = wr_valid & wr_ready;
`ifdef REG_BANK_ZERO_REG_EN
  assign wr_store = wr_fire & (wr_addr != '0);
`else
  assign wr_store = wr_fire;
`endif

  // Writes only happen in IDLE and sweep zeroing only in CLEAR, so the two never collide on an entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      wr_ready <= 1'b1;
      wr_ack   <= 1'b0;
      busy     <= 1'b0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      wr_ack <= wr_fire;
      if (wr_store) begin
        for (int b = 0; b < WIDTH/8; b++) begin
          if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      case (state)
        IDLE: begin
          if (clear_req) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          mem[clr_cnt] <= '0;
          clr_cnt      <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH-1)) begin
            state    <= IDLE;
            wr_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_q
`ifdef REG_BANK_ZERO_REG_EN
    if (k == 0) begin : g_zero
      assign q_flat[WIDTH-1:0] = '0;
    end else begin : g_ent
      assign q_flat[k*WIDTH +: WIDTH] = mem[k];
    end
`else
    assign q_flat[k*WIDTH +: WIDTH] = mem[k];
`endif
  end

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed bench for reg_bank_writer: inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_reg_bank_writer;

  localparam int DEPTH = 128;
  localparam int WIDTH = 32;
  localparam int ADDR_W = 7;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [WIDTH/8-1:0]     wr_be;
  logic                   wr_ack;
  logic                   clear_req;
  logic                   busy;
  logic [DEPTH*WIDTH-1:0] q_flat;

  int n_checks = 0;
  int n_fail   = 0;

  reg_bank_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .clear_req(clear_req), .busy(busy), .q_flat(q_flat)
  );

  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] ent(input int k);
    return q_flat[k*WIDTH +: WIDTH];
  endfunction

  // Drive one write so that it meets the next rising edge; returns at the following falling edge.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d, input logic [3:0] be);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    int nz;
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clear_req = 1'b0;
    #12;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    nz = 0;
    for (int k = 0; k < DEPTH; k++) if (ent(k) !== '0) nz++;
    n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL reset_q_flat: %0d nonzero entries, want 0", nz); end
  endtask

  task automatic test_write_readback;
    int bad;
    do_write(7'd5, 32'hDEADBEEF, 4'hF);
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack_pulse: got %b want 1", wr_ack); end
    n_checks++; if (q_flat[191:160] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL readback_5: got %h want deadbeef", q_flat[191:160]); end
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (k != 5 && ent(k) !== '0) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL others_zero: %0d nonzero entries, want 0", bad); end
    @(negedge clock);
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_single: got %b want 0", wr_ack); end
  endtask

  task automatic test_byte_enable;
    do_write(7'd9, 32'h11223344, 4'hF);
    do_write(7'd9, 32'hAABBCCDD, 4'h5);
    n_checks++; if (ent(9) !== 32'h11BB33DD) begin n_fail++; $display("FAIL be_merge: got %h want 11bb33dd", ent(9)); end
    do_write(7'd9, 32'hFFFFFFFF, 4'h0);
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL be0_ack: got %b want 1", wr_ack); end
    n_checks++; if (ent(9) !== 32'h11BB33DD) begin n_fail++; $display("FAIL be0_hold: got %h want 11bb33dd", ent(9)); end
    do_write(7'd9, 32'h99000000, 4'h8);
    n_checks++; if (ent(9) !== 32'h99BB33DD) begin n_fail++; $display("FAIL be_top: got %h want 99bb33dd", ent(9)); end
  endtask

  task automatic test_back_to_back_clear;
    int acks, busy_cnt, rdy_bad, late_acks, bad;
    logic done;
    acks = 0;
    wr_valid = 1'b1; wr_be = 4'hF;
    for (int a = 0; a < DEPTH; a++) begin
      wr_addr = ADDR_W'(a); wr_data = WIDTH'(a + 1);
      @(negedge clock);
      if (wr_ack) acks++;
    end
    wr_valid = 1'b0;
    n_checks++; if (acks !== DEPTH) begin n_fail++; $display("FAIL b2b_acks: got %0d want %0d", acks, DEPTH); end
`ifdef REG_BANK_ZERO_REG_EN
    n_checks++; if (ent(0) !== 32'd0) begin n_fail++; $display("FAIL fill_0: got %h want 0", ent(0)); end
`else
    n_checks++; if (ent(0) !== 32'd1) begin n_fail++; $display("FAIL fill_0: got %h want 1", ent(0)); end
`endif
    n_checks++; if (ent(127) !== 32'd128) begin n_fail++; $display("FAIL fill_127: got %h want 80", ent(127)); end
    n_checks++; if (ent(64) !== 32'd65) begin n_fail++; $display("FAIL fill_64: got %h want 41", ent(64)); end

    // clear_req held for three edges: the second and third land in CLEAR and must not restart it.
    clear_req = 1'b1;
    @(negedge clock);
    wr_valid = 1'b1; wr_addr = 7'd127; wr_data = 32'hCAFE0127; wr_be = 4'hF;
    busy_cnt = 0; rdy_bad = 0; acks = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (i == 2) clear_req = 1'b0;
      if (wr_ack) begin acks++; wr_valid = 1'b0; done = 1'b1; end
      else begin
        if (busy) busy_cnt++;
        if (busy && wr_ready) rdy_bad++;
        @(negedge clock);
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL clear_timeout: no wr_ack within 300 cycles"); end
    n_checks++; if (busy_cnt !== DEPTH) begin n_fail++; $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, DEPTH); end
    n_checks++; if (rdy_bad !== 0) begin n_fail++; $display("FAIL ready_in_clear: %0d cycles with wr_ready high, want 0", rdy_bad); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ack_after_busy: busy=%b at ack, want 0", busy); end
    late_acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (wr_ack) late_acks++;
    end
    n_checks++; if (acks + late_acks !== 1) begin n_fail++; $display("FAIL held_write_acks: got %0d want 1", acks + late_acks); end
    n_checks++; if (ent(127) !== 32'hCAFE0127) begin n_fail++; $display("FAIL held_write_data: got %h want cafe0127", ent(127)); end
    bad = 0;
    for (int k = 0; k < DEPTH - 1; k++) if (ent(k) !== '0) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL cleared_entries: %0d nonzero, want 0", bad); end
  endtask

  task automatic test_simultaneous;
    int hold;
    logic zeroed;
    wr_valid = 1'b1; wr_addr = 7'd3; wr_data = 32'h12345678; wr_be = 4'hF; clear_req = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0; clear_req = 1'b0;
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL simul_ack: got %b want 1", wr_ack); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy: got %b want 1", busy); end
    n_checks++; if (ent(3) !== 32'h12345678) begin n_fail++; $display("FAIL simul_data: got %h want 12345678", ent(3)); end
    hold = 0; zeroed = 1'b0;
    for (int i = 0; i < 10 && !zeroed; i++) begin
      @(negedge clock);
      if (ent(3) === 32'h12345678) hold++;
      else zeroed = 1'b1;
    end
    n_checks++; if (hold !== 3) begin n_fail++; $display("FAIL simul_hold: %0d further cycles, want 3", hold); end
    n_checks++; if (ent(3) !== 32'd0) begin n_fail++; $display("FAIL simul_zeroed: got %h want 0", ent(3)); end
    for (int i = 0; i < 300 && busy; i++) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_finish: busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset;
    int nz;
    do_write(7'd100, 32'hA5A5A5A5, 4'hF);
    clear_req = 1'b1;
    @(negedge clock);
    clear_req = 1'b0;
    // One falling edge after entering CLEAR the counter is 0; 40 more edges put it at 40.
    repeat (40) @(negedge clock);
    n_checks++; if (ent(100) !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL pre_reset_data: got %h want a5a5a5a5", ent(100)); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", busy); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", wr_ready); end
    nz = 0;
    for (int k = 0; k < DEPTH; k++) if (ent(k) !== '0) nz++;
    n_checks++; if (nz !== 0) begin n_fail++; $display("FAIL areset_q_flat: %0d nonzero entries, want 0", nz); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_reg;
    do_write(7'd0, 32'hFFFFFFFF, 4'hF);
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL zero_ack: got %b want 1", wr_ack); end
`ifdef REG_BANK_ZERO_REG_EN
    n_checks++; if (q_flat[31:0] !== 32'd0) begin n_fail++; $display("FAIL zero_entry: got %h want 0", q_flat[31:0]); end
`else
    n_checks++; if (q_flat[31:0] !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL zero_entry: got %h want ffffffff", q_flat[31:0]); end
`endif
    n_checks++; if (ent(1) !== 32'd0) begin n_fail++; $display("FAIL zero_neighbour: got %h want 0", ent(1)); end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_byte_enable();
    test_back_to_back_clear();
    test_simultaneous();
    test_async_reset();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_writer.md
Name: reg_bank_writer

Overview:
- Write side of the processor's 128-entry x 32-bit register bank.
- Holds the storage array, accepts writes through a valid/ready handshake with per-byte enables, and runs a bulk-clear sequencer.
- Exposes every entry on a flattened bus that the 128:1 read-select tree consumes.
- Sits between writeback and the read mux; owns all state of the bank.

Parameters:
DEPTH, 128, number of entries (power of two)
WIDTH, 32, bits per entry (multiple of 8)
ADDR_W, 7, log2(DEPTH)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
wr_valid  input  1  write request
wr_ready  output  1  bank can accept a write this cycle
wr_addr  input  ADDR_W  target entry
wr_data  input  WIDTH  write data
wr_be  input  WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i]
wr_ack  output  1  one-cycle pulse, the cycle after an accepted write
clear_req  input  1  request bulk clear of all entries
busy  output  1  clear sequence in progress
q_flat  output  DEPTH*WIDTH  entry k on bits [k*WIDTH+WIDTH-1 : k*WIDTH]

Behaviour:
- Reset (async, active-high, immediate):
  - all entries 0; state IDLE; clear counter 0
  - wr_ready=1, wr_ack=0, busy=0, q_flat all 0
- States:
  - IDLE: wr_ready=1, busy=0.
  - CLEAR: wr_ready=0, busy=1.
- Write acceptance:
  - A write is accepted on a rising edge with wr_valid & wr_ready.
  - Only enabled bytes of entry wr_addr update at that edge; other bytes and entries hold.
  - wr_be=0 is still accepted and still acks, but no data changes.
  - q_flat is driven directly from storage, with no output register: new data is visible the cycle after the accepting edge. Write-to-visible latency is 1 clock.
  - wr_ack=1 for exactly the cycle following each accepted write. Back-to-back accepts give a continuous wr_ack high.
- Clear sequence:
  - IDLE & clear_req at an edge -> CLEAR, counter=0.
  - In CLEAR, each edge zeroes entry[counter] and increments the counter.
  - On the edge that clears entry DEPTH-1: counter wraps to 0 and state -> IDLE.
  - Total: DEPTH edges in CLEAR, so busy is high for exactly DEPTH cycles.
- Boundary conditions:
  - clear_req while in CLEAR: ignored, no restart.
  - clear_req held high on exit: a new clear starts only from IDLE at a later edge. Requesting is level-sensitive in IDLE.
  - wr_valid while in CLEAR: not accepted, no ack; requester must hold the write until wr_ready.
  - Simultaneous wr_valid and clear_req in IDLE: the write is accepted and acked at that edge, and CLEAR starts at the same edge. That entry is later zeroed by the sweep.
  - wr_addr wraps naturally; every ADDR_W value is a valid entry.
  - Reset mid-CLEAR: abort immediately to IDLE; array zeroed by reset.
  - Reset mid-write: the write is lost and wr_ack is 0.

Optional Feature:
- Macro: REG_BANK_ZERO_REG_EN.
- Defined:
  - entry 0 is hardwired: q_flat[WIDTH-1:0] is constant 0
  - writes to address 0 are accepted and acked but discarded
  - the clear sweep still counts through address 0 (same DEPTH-cycle timing)
- Undefined: entry 0 is an ordinary storage entry.

Test Plan:
- Write then read back: reset, then write addr=5, data=0xDEADBEEF, be=0xF -> wr_ack high next cycle; q_flat[191:160]=0xDEADBEEF; all other entries 0.
- Byte-enable merge: entry 9 = 0x11223344, then write data=0xAABBCCDD, be=0x5 -> entry 9 = 0x11BB33DD.
- Full clear: fill addr 0..127 with value=addr+1, pulse clear_req for 1 cycle.
  - busy high for exactly 128 cycles; wr_ready low throughout.
  - All entries 0 afterward.
  - Write to addr=127 presented during CLEAR is accepted only after busy falls; exactly one wr_ack.
- Simultaneous write and clear: in IDLE, wr_valid(addr=3, 0x12345678) and clear_req on the same edge -> wr_ack next cycle; entry 3 reads 0x12345678 for exactly 3 cycles, then 0 after its sweep edge.
- Async reset mid-clear: assert reset at counter=40, between edges -> busy=0, wr_ready=1, q_flat=0 immediately, without waiting for a clock edge.
- Zero register (REG_BANK_ZERO_REG_EN defined): write addr=0, data=0xFFFFFFFF -> wr_ack pulses; q_flat[31:0] stays 0. With the macro undefined, the same write reads back 0xFFFFFFFF.
